// File: rtl/nasti_dma_pkg.sv
// Shared types for the DMA scheduler: FSM states, latched descriptor and the
// descriptor validity rule (non-zero length, whole mover beats only).
package nasti_dma_pkg;

   localparam int MAX_AW = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_START,
      ST_WAIT_DONE,
      ST_RESP
   } dma_state_t;

   typedef struct packed {
      logic [MAX_AW-1:0] src;
      logic [MAX_AW-1:0] dest;
      logic [MAX_AW-1:0] len;
   } dma_desc_t;

   // bytes is the mover beat size and must be a power of two
   function automatic logic desc_ok(input logic [MAX_AW-1:0] len, input int unsigned bytes);
      logic [MAX_AW-1:0] mask;
      mask = MAX_AW'(bytes - 1);
      return (len != '0) && ((len & mask) == '0);
   endfunction

endpackage

// File: rtl/nasti_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index at or after ptr
// wins; one-hot grant plus its index, all zero when en is low.
module nasti_rr_arbiter #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic found;
   int   idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      if (en) begin
         for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
               found        = 1'b1;
               gnt[idx]     = 1'b1;
               gnt_idx      = IW'(idx);
            end
         end
      end
   end

endmodule

// File: rtl/nasti_dma_scheduler.sv
// Shares one data mover among NUM_REQ requesters: round-robin grant in IDLE, mover start,
// done tracking with a start timeout, and a one-cycle completion pulse to the owner.
module nasti_dma_scheduler
   import nasti_dma_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int ADDR_WIDTH    = 64,
   parameter int DATA_WIDTH    = 64,
   parameter int START_TIMEOUT = 15
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_src,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_dest,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_len,
   output logic [NUM_REQ-1:0]              cmp_valid,
   output logic                            cmp_err,
   output logic [ADDR_WIDTH-1:0]           mv_src_addr,
   output logic [ADDR_WIDTH-1:0]           mv_dest_addr,
   output logic [ADDR_WIDTH-1:0]           mv_length,
   output logic                            mv_en,
   input  logic                            mv_done,
   output logic                            busy,
   output logic [$clog2(NUM_REQ)-1:0]      cur_owner,
   output logic [31:0]                     done_count
);

   localparam int IW    = $clog2(NUM_REQ);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int TW    = $clog2(START_TIMEOUT + 1);

   dma_state_t           state_q;
   dma_desc_t            desc_q;
   dma_desc_t            sel_desc;
   logic [IW-1:0]        owner_q;
   logic [IW-1:0]        rr_ptr_q;
   logic [IW-1:0]        rr_ptr_d;
   logic [IW-1:0]        gnt_idx;
   logic [NUM_REQ-1:0]   gnt;
   logic [NUM_REQ-1:0]   owner_oh;
   logic [NUM_REQ-1:0]   cmp_valid_q;
   logic                 cmp_err_q;
   logic                 err_q;
   logic                 mv_en_q;
   logic [TW-1:0]        tcnt_q;
   logic [TW-1:0]        tcnt_d;
   logic [31:0]          done_count_q;
   logic [31:0]          done_count_d;
   logic                 arb_en;
   logic                 accept;

   // A mover still busy from before reset (mv_done low) blocks new grants
   assign arb_en = (state_q == ST_IDLE) && mv_done;

   nasti_rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      sel_desc      = '0;
      sel_desc.src  = MAX_AW'(req_src [int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH]);
      sel_desc.dest = MAX_AW'(req_dest[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH]);
      sel_desc.len  = MAX_AW'(req_len [int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH]);
      rr_ptr_d      = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
      tcnt_d        = tcnt_q + TW'(1);
      done_count_d  = done_count_q + 32'd1;
      owner_oh      = NUM_REQ'(1) << owner_q;
      accept        = |gnt;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q      <= ST_IDLE;
         desc_q       <= '0;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         tcnt_q       <= '0;
         err_q        <= 1'b0;
         done_count_q <= '0;
         mv_en_q      <= 1'b0;
         cmp_valid_q  <= '0;
         cmp_err_q    <= 1'b0;
      end else begin
         mv_en_q     <= 1'b0;
         cmp_valid_q <= '0;
         cmp_err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  desc_q   <= sel_desc;
                  owner_q  <= gnt_idx;
                  rr_ptr_q <= rr_ptr_d;
                  if (desc_ok(sel_desc.len, BYTES)) begin
                     state_q <= ST_ISSUE;
                     mv_en_q <= 1'b1;
                  end else begin
                     state_q     <= ST_RESP;
                     err_q       <= 1'b1;
                     cmp_valid_q <= gnt;
                     cmp_err_q   <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               err_q   <= 1'b0;
               tcnt_q  <= '0;
               state_q <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               if (!mv_done) begin
                  state_q <= ST_WAIT_DONE;
               end else begin
                  tcnt_q <= tcnt_d;
                  if (tcnt_d == TW'(START_TIMEOUT)) begin
                     err_q       <= 1'b1;
                     state_q     <= ST_RESP;
                     cmp_valid_q <= owner_oh;
                     cmp_err_q   <= 1'b1;
                  end
               end
            end
            ST_WAIT_DONE: begin
               if (mv_done) begin
                  state_q     <= ST_RESP;
                  cmp_valid_q <= owner_oh;
                  cmp_err_q   <= err_q;
               end
            end
            ST_RESP: begin
               if (!err_q) begin
                  done_count_q <= done_count_d;
               end
               tcnt_q  <= '0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready    = gnt;
   assign cmp_valid    = cmp_valid_q;
   assign cmp_err      = cmp_err_q;
   assign mv_en        = mv_en_q;
   assign mv_src_addr  = desc_q.src[ADDR_WIDTH-1:0];
   assign mv_dest_addr = desc_q.dest[ADDR_WIDTH-1:0];
   assign mv_length    = desc_q.len[ADDR_WIDTH-1:0];
   assign busy         = (state_q != ST_IDLE);
   assign cur_owner    = owner_q;
   assign done_count   = done_count_q;

endmodule

// File: tb/tb_nasti_dma_scheduler.sv
// Directed bench for nasti_dma_scheduler with a behavioural mover and a completion scoreboard.
module tb_nasti_dma_scheduler;

   localparam int N  = 4;
   localparam int AW = 64;

   logic              aclk = 1'b0;
   logic              areset;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*AW-1:0]   req_src, req_dest, req_len;
   logic [N-1:0]      cmp_valid;
   logic              cmp_err;
   logic [AW-1:0]     mv_src_addr, mv_dest_addr, mv_length;
   logic              mv_en;
   logic              mv_done = 1'b1;
   logic              busy;
   logic [1:0]        cur_owner;
   logic [31:0]       done_count;

   always #5 aclk = ~aclk;

   nasti_dma_scheduler #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(64), .START_TIMEOUT(15)
   ) dut (
      .aclk(aclk), .areset(areset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src(req_src), .req_dest(req_dest), .req_len(req_len),
      .cmp_valid(cmp_valid), .cmp_err(cmp_err),
      .mv_src_addr(mv_src_addr), .mv_dest_addr(mv_dest_addr), .mv_length(mv_length),
      .mv_en(mv_en), .mv_done(mv_done),
      .busy(busy), .cur_owner(cur_owner), .done_count(done_count)
   );

   typedef struct { int owner; logic err; } cmp_exp_t;
   typedef struct { logic [63:0] s; logic [63:0] d; logic [63:0] l; } iss_exp_t;

   cmp_exp_t exp_cmp[$];
   iss_exp_t exp_iss[$];
   cmp_exp_t ce_m;
   iss_exp_t ie_m;

   int   errors = 0, checks = 0, cyc = 0;
   int   last_en = -1, last_cmp = -1, en_count = 0, exp_done = 0;
   int   lat = 3, cnt = 0;
   logic stuck = 1'b0, force_busy = 1'b0, pend = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   always @(posedge aclk) cyc <= cyc + 1;

   // Mover: done falls the cycle after it sees en, stays low lat+1 cycles
   always @(negedge aclk) begin
      if (areset) begin
         pend    = 1'b0;
         cnt     = 0;
         mv_done = 1'b1;
      end else if (force_busy) begin
         mv_done = 1'b0;
      end else begin
         if (pend) begin
            mv_done = 1'b0;
            cnt     = lat;
            pend    = 1'b0;
         end else if (!mv_done) begin
            if (cnt == 0) mv_done = 1'b1;
            else cnt--;
         end
         if (mv_en && !stuck) pend = 1'b1;
      end
   end

   always @(negedge aclk) begin
      if (areset) begin
         exp_cmp.delete();
         exp_iss.delete();
         exp_done = 0;
      end else begin
         if (mv_en === 1'b1) begin
            last_en = cyc;
            en_count++;
            if (exp_iss.size() == 0) chk("mv_en_unexpected", 1, 0);
            else begin
               ie_m = exp_iss.pop_front();
               chk("mv_src", mv_src_addr, ie_m.s);
               chk("mv_dest", mv_dest_addr, ie_m.d);
               chk("mv_len", mv_length, ie_m.l);
            end
         end
         if (cmp_valid !== '0) begin
            last_cmp = cyc;
            if (exp_cmp.size() == 0) chk("cmp_unexpected", 64'(cmp_valid), 0);
            else begin
               ce_m = exp_cmp.pop_front();
               chk("cmp_owner", 64'(cmp_valid), 64'(1 << ce_m.owner));
               chk("cmp_err", 64'(cmp_err), 64'(ce_m.err));
               if (!ce_m.err) exp_done++;
            end
         end
      end
   end

   task automatic step();
      @(posedge aclk);
      #2;
   endtask

   task automatic set_desc(input int g, input logic [63:0] s, input logic [63:0] d, input logic [63:0] l);
      req_src[g*AW +: AW]  = s;
      req_dest[g*AW +: AW] = d;
      req_len[g*AW +: AW]  = l;
   endtask

   task automatic push_exp(input int g);
      logic [63:0] l;
      logic        ok;
      l  = req_len[g*AW +: AW];
      ok = (l != 64'd0) && (l[2:0] == 3'd0);
      exp_cmp.push_back('{owner: g, err: (!ok || stuck)});
      if (ok) exp_iss.push_back('{s: req_src[g*AW +: AW], d: req_dest[g*AW +: AW], l: l});
   endtask

   task automatic offer(input int g, input logic [63:0] s, input logic [63:0] d,
                        input logic [63:0] l, output int acc);
      int n;
      n = 0;
      set_desc(g, s, d, l);
      req_valid[g] = 1'b1;
      #1;
      while (req_ready[g] !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("grant_seen", 64'(req_ready[g]), 1);
      acc = cyc;
      if (req_ready[g] === 1'b1) push_exp(g);
      step();
      req_valid[g] = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy !== 1'b0 || exp_cmp.size() != 0) && n < 500) begin
         step();
         n++;
      end
      chk("idle_reached", 64'(n < 500), 1);
   endtask

   task automatic check_reset_outputs();
      chk("rst_mv_en", 64'(mv_en), 0);
      chk("rst_cmp_valid", 64'(cmp_valid), 0);
      chk("rst_cmp_err", 64'(cmp_err), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_cur_owner", 64'(cur_owner), 0);
      chk("rst_mv_src", mv_src_addr, 0);
      chk("rst_mv_dest", mv_dest_addr, 0);
      chk("rst_mv_len", mv_length, 0);
      chk("rst_done_count", 64'(done_count), 0);
      chk("rst_req_ready", 64'(req_ready), 0);
   endtask

   initial begin
      int acc, gi, k, n, en_before;
      areset    = 1'b1;
      req_valid = '0;
      req_src   = '0;
      req_dest  = '0;
      req_len   = '0;
      repeat (3) step();
      check_reset_outputs();
      areset = 1'b0;
      step();

      // single valid transfer from requester 0
      lat = 4;
      offer(0, 64'h1000, 64'h8000, 64'h800, acc);
      wait_idle();
      chk("t1_en_cycle", 64'(last_en), 64'(acc + 1));
      chk("t1_done_count", 64'(done_count), 1);
      chk("t1_hold_src", mv_src_addr, 64'h1000);

      // bad lengths rejected without starting the mover
      en_before = en_count;
      offer(2, 64'h2000, 64'h3000, 64'h0, acc);
      wait_idle();
      chk("bad0_cmp_cycle", 64'(last_cmp), 64'(acc + 1));
      offer(2, 64'h2000, 64'h3000, 64'h804, acc);
      wait_idle();
      chk("bad804_cmp_cycle", 64'(last_cmp), 64'(acc + 1));
      chk("bad_no_en", 64'(en_count), 64'(en_before));
      chk("bad_done_count", 64'(done_count), 1);

      // start timeout, then a normal transfer
      stuck = 1'b1;
      offer(3, 64'h4000, 64'h5000, 64'h40, acc);
      wait_idle();
      chk("to_en_cycle", 64'(last_en), 64'(acc + 1));
      chk("to_cmp_cycle", 64'(last_cmp), 64'(last_en + 16));
      stuck = 1'b0;
      offer(1, 64'h6000, 64'h7000, 64'h100, acc);
      wait_idle();
      chk("after_to_count", 64'(done_count), 2);

      // reset during WAIT_DONE of a long copy
      lat = 40;
      offer(0, 64'h9000, 64'hA000, 64'h10000, acc);
      repeat (6) step();
      chk("mid_busy", 64'(busy), 1);
      chk("mid_done_low", 64'(mv_done), 0);
      areset = 1'b1;
      step();
      areset = 1'b0;
      check_reset_outputs();
      lat = 3;
      repeat (5) step();

      // fairness with all requesters holding valid
      for (int g = 0; g < N; g++) set_desc(g, 64'h10000 * (g + 1), 64'h80000 + 64'h1000 * g, 64'h40 * (g + 1));
      req_valid = '1;
      #1;
      k = 0;
      n = 0;
      while (k < 8 && n < 2000) begin
         if (req_ready !== '0) begin
            gi = -1;
            for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
            chk("fair_onehot", 64'($countones(req_ready)), 1);
            chk("fair_order", 64'(gi), 64'(k % 4));
            push_exp(gi);
            k++;
            step();
            set_desc(gi, 64'h100000 + 64'h100 * k, 64'h200000 + 64'h100 * k, 64'h80 + 64'h8 * k);
            if (k == 8) req_valid = '0;
         end else begin
            step();
         end
         n++;
      end
      chk("fair_grants", 64'(k), 8);
      wait_idle();
      chk("fair_done_model", 64'(done_count), 64'(exp_done));
      chk("fair_done_count", 64'(done_count), 8);

      // mover busy at entry blocks the grant until done rises
      force_busy = 1'b1;
      step();
      step();
      chk("busy_done_low", 64'(mv_done), 0);
      set_desc(1, 64'hC000, 64'hD000, 64'h20);
      req_valid[1] = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("busy_no_ready", 64'(req_ready), 0);
         step();
      end
      force_busy = 1'b0;
      @(negedge aclk);
      #1;
      chk("busy_done_rose", 64'(mv_done), 1);
      chk("busy_ready", 64'(req_ready), 64'h2);
      if (req_ready[1] === 1'b1) push_exp(1);
      acc = cyc;
      step();
      req_valid[1] = 1'b0;
      wait_idle();
      chk("busy_en_cycle", 64'(last_en), 64'(acc + 1));
      chk("busy_done_count", 64'(done_count), 9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
